// File: rtl/fxp_pkg.sv
// Shared constants and state encoding for the Q32.32 fixed-point datapath.
package fxp_pkg;

  localparam int W_DEF    = 64;
  localparam int FRAC_DEF = 32;

  localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
  localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MAX_NEG = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fxp_mul_seq_if.sv
// Operand/result valid-ready bundle between the multiplier and its neighbours.
import fxp_pkg::*;

interface fxp_mul_seq_if #(parameter int W = W_DEF);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         ovf;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, c, ovf);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, c, ovf);
endinterface

// File: rtl/fxp_mul_step.sv
// One shift-add iteration: adds |a| * (BPC multiplier bits) into the upper half
// of the product accumulator, then shifts the accumulator right by BPC.
module fxp_mul_step #(
  parameter int W   = 64,
  parameter int BPC = 1
) (
  input  logic [2*W-1:0] i_acc,
  input  logic [W-1:0]   i_mag_a,
  input  logic [BPC-1:0] i_bits,
  output logic [2*W-1:0] o_acc
);

  logic [W+BPC-1:0] w_pp;
  logic [W+BPC-1:0] w_sum;

  // The sum cannot exceed 2^(W+BPC)-1, so no carry is lost.
  assign w_pp  = {{BPC{1'b0}}, i_mag_a} * {{W{1'b0}}, i_bits};
  assign w_sum = {{BPC{1'b0}}, i_acc[2*W-1:W]} + w_pp;
  assign o_acc = {w_sum, i_acc[W-1:BPC]};

endmodule

// File: rtl/fxp_mul_seq.sv
// Sequential signed fixed-point multiplier: c = (a*b) >>> FRAC using an
// iterative shift-add over operand magnitudes, valid/ready on both sides.
import fxp_pkg::*;

module fxp_mul_seq #(
  parameter int W        = W_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int BPC      = 1,
  parameter bit SATURATE = 1'b0
) (
  input logic          clk,
  input logic          rst,
  fxp_mul_seq_if.slave bus
);

  localparam int NITER = W / BPC;
  localparam int CW    = $clog2(NITER + 1);
  localparam int HW    = 2*W - FRAC;

  state_e         r_state;
  logic [W-1:0]   r_mag_a;
  logic [W-1:0]   r_mag_b;
  logic           r_sign;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_c;
  logic           r_ovf;
  logic           r_in_ready;
  logic           r_out_valid;

  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [2*W-1:0] w_acc_next;
  logic           w_lo_zero;
  logic [HW-1:0]  w_hi;
  logic [HW-1:0]  w_prod_hi;
  logic           w_ovf;
  logic [W-1:0]   w_c_fin;

  // |-2^(W-1)| wraps to 2^(W-1), which is exact as an unsigned W-bit value.
  assign w_abs_a = bus.a[W-1] ? -bus.a : bus.a;
  assign w_abs_b = bus.b[W-1] ? -bus.b : bus.b;

  fxp_mul_step #(.W(W), .BPC(BPC)) u_step (
    .i_acc   (r_acc),
    .i_mag_a (r_mag_a),
    .i_bits  (r_mag_b[BPC-1:0]),
    .o_acc   (w_acc_next)
  );

  // Two's-complement negation seen only above FRAC: the low bits discarded by
  // the slice contribute just the +1 carry, and only when they are all zero.
  assign w_lo_zero = ~|r_acc[FRAC-1:0];
  assign w_hi      = r_acc[2*W-1:FRAC];
  assign w_prod_hi = r_sign ? (~w_hi + {{(HW-1){1'b0}}, w_lo_zero}) : w_hi;

  assign w_ovf = !((&w_prod_hi[HW-1:W-1]) || (~|w_prod_hi[HW-1:W-1]));

  always_comb begin
    w_c_fin = w_prod_hi[W-1:0];
    if (SATURATE && w_ovf)
      w_c_fin = r_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // NOTE: sequential state uses non-blocking assignments only, and the whole
  // datapath is reset along with the FSM so no X can reach c or ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_sign      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mag_a    <= w_abs_a;
            r_mag_b    <= w_abs_b;
            r_sign     <= bus.a[W-1] ^ bus.b[W-1];
            r_acc      <= '0;
            r_cnt      <= CW'(NITER);
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_acc   <= w_acc_next;
          r_mag_b <= r_mag_b >> BPC;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            r_state <= FIN;
        end
        FIN: begin
          r_c         <= w_c_fin;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Directed bench for fxp_mul_seq: a wrapping and a saturating instance driven
// with identical stimulus, hand-computed Q32.32 results checked on both.
module tb_fxp_mul_seq;
  import fxp_pkg::*;

  localparam int W    = 64;
  localparam int FRAC = 32;
  localparam int BPC  = 1;
  // Cycles from the accepting cycle to the first cycle with out_valid high.
  localparam int LAT  = W/BPC + 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fxp_mul_seq_if #(.W(W)) bus_w ();
  fxp_mul_seq_if #(.W(W)) bus_s ();

  fxp_mul_seq #(.W(W), .FRAC(FRAC), .BPC(BPC), .SATURATE(1'b0)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  fxp_mul_seq #(.W(W), .FRAC(FRAC), .BPC(BPC), .SATURATE(1'b1)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b);
    bus_w.in_valid = v; bus_w.a = a; bus_w.b = b;
    bus_s.in_valid = v; bus_s.a = a; bus_s.b = b;
  endtask

  task automatic set_ready(input logic r);
    bus_w.out_ready = r;
    bus_s.out_ready = r;
  endtask

  task automatic check_idle(input string tag, input logic [63:0] exp_c, input logic exp_ovf);
    check({tag, "/w_in_ready"},  64'(bus_w.in_ready),  64'd1);
    check({tag, "/s_in_ready"},  64'(bus_s.in_ready),  64'd1);
    check({tag, "/w_out_valid"}, 64'(bus_w.out_valid), 64'd0);
    check({tag, "/s_out_valid"}, 64'(bus_s.out_valid), 64'd0);
    check({tag, "/w_c"},         bus_w.c,              exp_c);
    check({tag, "/s_c"},         bus_s.c,              exp_c);
    check({tag, "/w_ovf"},       64'(bus_w.ovf),       64'(exp_ovf));
    check({tag, "/s_ovf"},       64'(bus_s.ovf),       64'(exp_ovf));
  endtask

  // Present operands for one cycle, wait for the result within a bounded
  // window, then check latency and both results and complete the handshake.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] cw, input logic ow,
                        input logic [63:0] cs, input logic os);
    int lat;
    @(negedge clk);
    check({tag, "/in_ready"}, 64'(bus_w.in_ready), 64'd1);
    drive(1'b1, a, b);
    @(negedge clk);
    drive(1'b0, '0, '0);
    lat = 1;
    while (bus_w.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"},     64'(lat),             64'(LAT));
    check({tag, "/s_out_valid"}, 64'(bus_s.out_valid), 64'd1);
    check({tag, "/w_c"},         bus_w.c,              cw);
    check({tag, "/w_ovf"},       64'(bus_w.ovf),       64'(ow));
    check({tag, "/s_c"},         bus_s.c,              cs);
    check({tag, "/s_ovf"},       64'(bus_s.ovf),       64'(os));
    set_ready(1'b1);
    @(negedge clk);
    set_ready(1'b0);
    check({tag, "/out_valid_drop"}, 64'(bus_w.out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    drive(1'b0, '0, '0);
    set_ready(1'b0);
    repeat (3) @(negedge clk);
    check_idle("reset", 64'd0, 1'b0);
    rst = 1'b0;

    run_op("p1p5_x_p2",  64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000,
           64'h0000_0003_0000_0000, 1'b0, 64'h0000_0003_0000_0000, 1'b0);
    run_op("n1p5_x_p2",  64'hFFFF_FFFE_8000_0000, 64'h0000_0002_0000_0000,
           64'hFFFF_FFFD_0000_0000, 1'b0, 64'hFFFF_FFFD_0000_0000, 1'b0);
    run_op("n1p5_x_n2",  64'hFFFF_FFFE_8000_0000, 64'hFFFF_FFFE_0000_0000,
           64'h0000_0003_0000_0000, 1'b0, 64'h0000_0003_0000_0000, 1'b0);
    run_op("floor",      64'h0000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("zero_x_n5",  64'h0000_0000_0000_0000, 64'hFFFF_FFFB_0000_0000,
           64'h0, 1'b0, 64'h0, 1'b0);
    run_op("ovf_2p20sq", 64'h0010_0000_0000_0000, 64'h0010_0000_0000_0000,
           64'h0, 1'b1, MAX_POS, 1'b1);
    run_op("ovf_minsq",  MAX_NEG, MAX_NEG,
           64'h0, 1'b1, MAX_POS, 1'b1);
    run_op("ovf_neg",    MAX_NEG, 64'h0000_0002_0000_0000,
           64'h0, 1'b1, MAX_NEG, 1'b1);
    run_op("min_x_one",  MAX_NEG, ONE,
           MAX_NEG, 1'b0, MAX_NEG, 1'b0);

    // Backpressure: result held for 10 cycles while new operands are offered.
    @(negedge clk);
    drive(1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFE_0000_0000);
    @(negedge clk);
    drive(1'b0, '0, '0);
    lat = 1;
    while (bus_w.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("bp/latency", 64'(lat), 64'(LAT));
    drive(1'b1, ONE, ONE);
    for (int i = 0; i < 10; i++) begin
      check("bp/c",         bus_w.c,              64'hFFFF_FFFD_0000_0000);
      check("bp/ovf",       64'(bus_w.ovf),       64'd0);
      check("bp/out_valid", 64'(bus_w.out_valid), 64'd1);
      check("bp/in_ready",  64'(bus_w.in_ready),  64'd0);
      @(negedge clk);
    end
    drive(1'b0, '0, '0);
    set_ready(1'b1);
    @(negedge clk);
    set_ready(1'b0);
    check_idle("bp_release", 64'hFFFF_FFFD_0000_0000, 1'b0);

    // Reset in the 30th BUSY cycle discards the operation and clears c.
    @(negedge clk);
    drive(1'b1, 64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000);
    @(negedge clk);
    drive(1'b0, '0, '0);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset", 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_reset/no_output", 64'(bus_w.out_valid), 64'd0);

    run_op("one_x_one", ONE, ONE, ONE, 1'b0, ONE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
